// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO and models the iterative
// unit's latency while computing the result up front at the start edge.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic          dz_q, dz_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic op_mul, op_div, op_mthi, op_mtlo;

  assign op_mul  = (mdop == 3'd0) || (mdop == 3'd1);
  assign op_div  = (mdop == 3'd2) || (mdop == 3'd3);
  assign op_mthi = (mdop == 3'd4);
  assign op_mtlo = (mdop == 3'd5);

  logic        msgn;
  logic [63:0] ma, mb, prod;

  assign msgn = (mdop == 3'd0);
  assign ma   = {{32{msgn & rs_val[31]}}, rs_val};
  assign mb   = {{32{msgn & rt_val[31]}}, rt_val};
  assign prod = ma * mb;

  // Divide on magnitudes so INT_MIN / -1 wraps cleanly instead of overflowing.
  logic        dsgn, a_neg, b_neg, dz;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign dsgn   = (mdop == 3'd2);
  assign a_neg  = dsgn & rs_val[31];
  assign b_neg  = dsgn & rt_val[31];
  assign a_mag  = a_neg ? -rs_val : rs_val;
  assign b_mag  = b_neg ? -rt_val : rt_val;
  assign dz     = (rt_val == 32'd0);
  assign b_safe = dz ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            op_mul: begin
              state_d  = MULT;
              cnt_d    = CW'(MULT_CYCLES - 1);
              res_hi_d = prod[63:32];
              res_lo_d = prod[31:0];
              dz_d     = 1'b0;
            end
            op_div: begin
              state_d  = DIV;
              cnt_d    = CW'(DIV_CYCLES - 1);
              res_hi_d = rem;
              res_lo_d = quot;
              dz_d     = dz;
            end
            op_mthi: hi_d = rs_val;
            op_mtlo: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          if (!dz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: timing, results and cancel paths.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start  = 1'b1;
    mdop   = op;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    mdop = 3'd0; rs_val = '0; rt_val = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++;
      $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++;
      $display("FAIL reset_lo got %h exp 0", lo); end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    checks++; if (hi !== 32'h0) begin errors++;
      $display("FAIL mult_hi_early got %h exp 0", hi); end
    count_busy(n);
    checks++; if (n != 5) begin errors++;
      $display("FAIL mult_cycles got %0d exp 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++;
      $display("FAIL mult_lo got %h exp fffffffa", lo); end
  endtask

  task automatic test_multu_div();
    int n;
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    count_busy(n);
    checks++; if (n != 5) begin errors++;
      $display("FAIL multu_cycles got %0d exp 5", n); end
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL multu_res got %h_%h exp 00000001_fffffffe", hi, lo); end
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++;
      $display("FAIL div_cycles got %0d exp 10", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL div_res got %h_%h exp ffffffff_fffffffd", hi, lo); end
    issue(3'd3, 32'd100, 32'd7);
    count_busy(n);
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++;
      $display("FAIL divu_res got %h_%h exp 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_mthi_divz();
    int n;
    issue(3'd4, 32'h12345678, 32'h0);
    checks++; if (hi !== 32'h12345678 || busy !== 1'b0) begin errors++;
      $display("FAIL mthi got hi %h busy %b exp 12345678 0", hi, busy); end
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    checks++; if (lo !== 32'hCAFEF00D || busy !== 1'b0) begin errors++;
      $display("FAIL mtlo got lo %h busy %b exp cafef00d 0", lo, busy); end
    issue(3'd3, 32'd1234, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++;
      $display("FAIL divz_cycles got %0d exp 10", n); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin errors++;
      $display("FAIL divz_keep got %h_%h exp 12345678_cafef00d", hi, lo); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++;
      $display("FAIL div_ovf got %h_%h exp 00000000_80000000", hi, lo); end
  endtask

  task automatic test_cancel();
    int n;
    issue(3'd4, 32'hA5A5A5A5, 32'h0);
    issue(3'd2, 32'd100, 32'd7);
    step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL flush_busy got %b exp 0", busy); end
    step(); step();
    checks++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h80000000) begin errors++;
      $display("FAIL flush_keep got %h_%h exp a5a5a5a5_80000000", hi, lo); end
    flush = 1'b1;
    issue(3'd0, 32'd2, 32'd2);
    issue(3'd4, 32'h11111111, 32'd0);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL flush_start got busy %b hi %h exp 0 a5a5a5a5", busy, hi); end
    issue(3'd6, 32'd3, 32'd3);
    issue(3'd7, 32'd3, 32'd3);
    checks++; if (busy !== 1'b0 || hi !== 32'hA5A5A5A5 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL reserved got busy %b %h_%h exp 0 a5a5a5a5_80000000",
               busy, hi, lo);
    end
    issue(3'd1, 32'd3, 32'd4);
    start = 1'b1; mdop = 3'd0; rs_val = 32'd5; rt_val = 32'd5;
    step(); step();
    start = 1'b0;
    count_busy(n);
    checks++; if (n != 3) begin errors++;
      $display("FAIL ignore_cycles got %0d exp 3", n); end
    checks++; if (hi !== 32'h0 || lo !== 32'd12) begin errors++;
      $display("FAIL ignore_res got %h_%h exp 00000000_0000000c", hi, lo); end
    step();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL ignore_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    int total;
    issue(3'd4, 32'h77777777, 32'd0);
    issue(3'd0, 32'd9, 32'd9);
    step(); step();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++;
      $display("FAIL async_reset got busy %b %h_%h exp 0 0_0", busy, hi, lo); end
    #1 reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || hi !== 32'h0) begin errors++;
      $display("FAIL post_reset got busy %b hi %h exp 0 0", busy, hi); end
    total = 0;
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    count_busy(n);
    total += n;
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++;
      $display("FAIL b2b_mult got %h_%h exp ffffffff_ffffffeb", hi, lo); end
    issue(3'd1, 32'h00010000, 32'h00010000);
    count_busy(n);
    total += n;
    checks++; if (total != 10) begin errors++;
      $display("FAIL b2b_cycles got %0d exp 10", total); end
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++;
      $display("FAIL b2b_multu got %h_%h exp 00000001_00000000", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_mthi_divz();
    test_cancel();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
